// File: rtl/wb_trace_checker.sv
// wb_trace_checker: in-order checker of GPR/HI/LO writeback events
// against a preloaded table of expected architectural writes.
module wb_trace_checker #(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 5,
  parameter int DEPTH     = 64,
  parameter int IDX_W     = 6,
  parameter int TIMEOUT   = 1024,
  parameter int TO_W      = 11,
  parameter int IGNORE_R0 = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               load_we,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic [1:0]         load_kind,
  input  logic [RADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0]  wb_wdata,
  input  logic               hilo_we,
  input  logic [DATA_W-1:0]  hi,
  input  logic [DATA_W-1:0]  lo,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [1:0]         err_code,
  output logic [IDX_W-1:0]   err_idx,
  output logic [DATA_W-1:0]  err_data,
  output logic [IDX_W-1:0]   match_cnt
);

  localparam logic [1:0] K_GPR = 2'd0;
  localparam logic [1:0] K_HI  = 2'd1;
  localparam logic [1:0] K_LO  = 2'd2;
  localparam logic [1:0] K_END = 2'd3;

  // ptr must be able to sit one past the last entry
  localparam int PW = IDX_W + 1;
  localparam int EW = IDX_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [TO_W-1:0]   to_inc;
  logic [IDX_W-1:0]  mcnt_q, mcnt_d;
  logic [1:0]        code_q, code_d;
  logic [IDX_W-1:0]  eidx_q, eidx_d;
  logic [DATA_W-1:0] edata_q, edata_d;
  logic              busy_q, done_q, pass_q;

  logic [1:0]         tbl_kind_q [DEPTH];
  logic [RADDR_W-1:0] tbl_addr_q [DEPTH];
  logic [DATA_W-1:0]  tbl_data_q [DEPTH];
  logic               load_ok;

  logic [EW-1:0]      ent_idx  [3];
  logic [1:0]         ent_kind [3];
  logic [RADDR_W-1:0] ent_addr [3];
  logic [DATA_W-1:0]  ent_data [3];

  logic               gpr_ev;
  logic [1:0]         n_ev;
  logic [1:0]         hl_base;
  logic [1:0]         ev_kind [3];
  logic [RADDR_W-1:0] ev_addr [3];
  logic [DATA_W-1:0]  ev_data [3];

  logic               mis;
  logic [1:0]         mis_code;
  logic [1:0]         mis_slot;
  logic [DATA_W-1:0]  mis_data;

  // Table is writable only while no run is in progress
  always_comb begin
    load_ok = load_we && (state_q != S_RUN)
            && ({1'b0, load_idx} < PW'(DEPTH));
  end

  // Kind column resets to END so an unloaded table passes trivially
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_kind_q[i] <= K_END;
      end
    end else if (load_ok) begin
      tbl_kind_q[load_idx] <= load_kind;
    end
  end

  // Address/data columns carry no reset
  always_ff @(posedge clk) begin
    if (load_ok) begin
      tbl_addr_q[load_idx] <= load_addr;
      tbl_data_q[load_idx] <= load_data;
    end
  end

  // Look up the three entries an event burst could consume
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ent_idx[i]  = EW'(ptr_q) + EW'(i);
      ent_kind[i] = K_END;
      ent_addr[i] = '0;
      ent_data[i] = '0;
      if (ent_idx[i] < EW'(DEPTH)) begin
        ent_kind[i] = tbl_kind_q[ent_idx[i][IDX_W-1:0]];
        ent_addr[i] = tbl_addr_q[ent_idx[i][IDX_W-1:0]];
        ent_data[i] = tbl_data_q[ent_idx[i][IDX_W-1:0]];
      end
    end
  end

  // Pack this cycle's writes into ordered slots: GPR, HI, LO
  always_comb begin
    gpr_ev  = wb_we && !((IGNORE_R0 != 0) && (wb_waddr == '0));
    hl_base = {1'b0, gpr_ev};
    n_ev    = {hilo_we, 1'b0} + {1'b0, gpr_ev};
    for (int i = 0; i < 3; i++) begin
      ev_kind[i] = K_END;
      ev_addr[i] = '0;
      ev_data[i] = '0;
    end
    if (gpr_ev) begin
      ev_kind[0] = K_GPR;
      ev_addr[0] = wb_waddr;
      ev_data[0] = wb_wdata;
    end
    if (hilo_we) begin
      ev_kind[hl_base]        = K_HI;
      ev_data[hl_base]        = hi;
      ev_kind[hl_base + 2'd1] = K_LO;
      ev_data[hl_base + 2'd1] = lo;
    end
  end

  // Find the lowest slot whose event disagrees with its entry
  always_comb begin
    mis      = 1'b0;
    mis_code = 2'd0;
    mis_slot = 2'd0;
    mis_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (!mis && (2'(i) < n_ev)) begin
        if (ent_kind[i] != ev_kind[i]) begin
          mis      = 1'b1;
          mis_code = 2'd2;
          mis_slot = 2'(i);
          mis_data = ev_data[i];
        end else if ((ent_data[i] != ev_data[i])
                  || ((ev_kind[i] == K_GPR)
                   && (ent_addr[i] != ev_addr[i]))) begin
          mis      = 1'b1;
          mis_code = 2'd1;
          mis_slot = 2'(i);
          mis_data = ev_data[i];
        end
      end
    end
  end

  // Next-state: mismatch beats progress beats completion beats timeout
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    to_d    = to_q;
    mcnt_d  = mcnt_q;
    code_d  = code_q;
    eidx_d  = eidx_q;
    edata_d = edata_q;
    to_inc  = to_q + TO_W'(1);
    unique case (state_q)
      S_RUN: begin
        if (mis) begin
          state_d = S_FAIL;
          code_d  = mis_code;
          eidx_d  = ptr_q[IDX_W-1:0] + IDX_W'(mis_slot);
          edata_d = mis_data;
        end else if (n_ev != 2'd0) begin
          ptr_d  = ptr_q + PW'(n_ev);
          mcnt_d = mcnt_q + IDX_W'(n_ev);
          to_d   = '0;
        end else if (ent_kind[0] == K_END) begin
          state_d = S_PASS;
        end else begin
          to_d = to_inc;
          if (to_inc == TO_W'(TIMEOUT)) begin
            state_d = S_FAIL;
            code_d  = 2'd3;
            eidx_d  = ptr_q[IDX_W-1:0];
            edata_d = '0;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          ptr_d   = '0;
          to_d    = '0;
          mcnt_d  = '0;
          code_d  = 2'd0;
          eidx_d  = '0;
          edata_d = '0;
        end
      end
    endcase
  end

  // Checker state and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      to_q    <= '0;
      mcnt_q  <= '0;
      code_q  <= 2'd0;
      eidx_q  <= '0;
      edata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      to_q    <= to_d;
      mcnt_q  <= mcnt_d;
      code_q  <= code_d;
      eidx_q  <= eidx_d;
      edata_q <= edata_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_PASS) || (state_d == S_FAIL);
      pass_q  <= (state_d == S_PASS);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_code  = code_q;
  assign err_idx   = eidx_q;
  assign err_data  = edata_q;
  assign match_cnt = mcnt_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: random and directed event streams
// compared against an event-queue model of the checker.
module tb_wb_trace_checker;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 12;
  localparam int IW    = 4;
  localparam int TMO   = 16;
  localparam int TOW   = 5;

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_PASS = 2;
  localparam int ST_FAIL = 3;

  localparam logic [1:0] KG = 2'd0;
  localparam logic [1:0] KH = 2'd1;
  localparam logic [1:0] KL = 2'd2;
  localparam logic [1:0] KE = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          load_we;
  logic [IW-1:0] load_idx;
  logic [1:0]    load_kind;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          hilo_we;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic          busy;
  logic          done;
  logic          pass;
  logic [1:0]    err_code;
  logic [IW-1:0] err_idx;
  logic [DW-1:0] err_data;
  logic [IW-1:0] match_cnt;

  wb_trace_checker #(
    .DATA_W(DW), .RADDR_W(AW), .DEPTH(DEPTH), .IDX_W(IW),
    .TIMEOUT(TMO), .TO_W(TOW), .IGNORE_R0(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_we(load_we), .load_idx(load_idx),
    .load_kind(load_kind), .load_addr(load_addr),
    .load_data(load_data),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .hilo_we(hilo_we), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .pass(pass),
    .err_code(err_code), .err_idx(err_idx),
    .err_data(err_data), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    k;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          tbl [DEPTH];
  int            m_st, m_ptr, m_cnt, m_code, m_idx, m_to;
  logic [DW-1:0] m_data;
  int            n_vec = 0;
  int            n_err = 0;
  bit            ld_noise = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = ST_IDLE; m_ptr = 0; m_cnt = 0;
    m_code = 0; m_idx = 0; m_to = 0; m_data = '0;
    for (int i = 0; i < DEPTH; i++) tbl[i].k = KE;
  endfunction

  function automatic ent_t entry(input int i);
    ent_t e;
    e.k = KE; e.a = '0; e.d = '0;
    if (i < DEPTH) e = tbl[i];
    return e;
  endfunction

  // One clock edge of the reference: events vs. expected queue head
  function automatic void model_edge();
    ent_t ev[$];
    ent_t x, e;
    int   old, bad, code;
    old = m_st;
    bad = -1;
    code = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_st == ST_RUN) begin
      if (wb_we && wb_waddr != 0) begin
        x.k = KG; x.a = wb_waddr; x.d = wb_wdata; ev.push_back(x);
      end
      if (hilo_we) begin
        x.k = KH; x.a = '0; x.d = hi; ev.push_back(x);
        x.k = KL; x.d = lo; ev.push_back(x);
      end
      if (ev.size() == 0) begin
        if (entry(m_ptr).k == KE) m_st = ST_PASS;
        else begin
          m_to++;
          if (m_to == TMO) begin
            m_st = ST_FAIL; m_code = 3; m_idx = m_ptr; m_data = '0;
          end
        end
      end else begin
        foreach (ev[j]) begin
          if (bad < 0) begin
            e = entry(m_ptr + j);
            if (e.k != ev[j].k) begin
              bad = j; code = 2;
            end else if (e.d != ev[j].d ||
                         (e.k == KG && e.a != ev[j].a)) begin
              bad = j; code = 1;
            end
          end
        end
        if (bad >= 0) begin
          m_st = ST_FAIL; m_code = code;
          m_idx = m_ptr + bad; m_data = ev[bad].d;
        end else begin
          m_ptr += ev.size(); m_cnt += ev.size(); m_to = 0;
        end
      end
    end else if (start) begin
      m_st = ST_RUN; m_ptr = 0; m_cnt = 0;
      m_code = 0; m_idx = 0; m_data = '0; m_to = 0;
    end
    if (load_we && old != ST_RUN && int'(load_idx) < DEPTH)
      tbl[load_idx] = '{load_kind, load_addr, load_data};
  endfunction

  task automatic cmp_all();
    chk("busy", busy, m_st == ST_RUN);
    chk("done", done, m_st == ST_PASS || m_st == ST_FAIL);
    chk("pass", pass, m_st == ST_PASS);
    chk("match_cnt", match_cnt, m_cnt[IW-1:0]);
    chk("err_code", err_code, m_code[1:0]);
    chk("err_idx", err_idx, m_idx[IW-1:0]);
    chk("err_data", err_data, m_data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic quiet();
    start = 0; load_we = 0; load_idx = '0; load_kind = '0;
    load_addr = '0; load_data = '0;
    wb_we = 0; wb_waddr = '0; wb_wdata = '0;
    hilo_we = 0; hi = '0; lo = '0;
  endtask

  task automatic noise();
    if (ld_noise) begin
      load_we = 1; load_idx = IW'($urandom_range(0, 15));
      load_kind = 2'($urandom); load_addr = AW'($urandom);
      load_data = $urandom;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      wb_we = 1'($urandom_range(0, 1));
      wb_waddr = '0; wb_wdata = $urandom; hilo_we = 0;
      noise();
      step();
    end
    quiet();
  endtask

  task automatic ev_cycle(input bit g, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit h,
                          input logic [DW-1:0] hv,
                          input logic [DW-1:0] lv);
    if (g) begin
      wb_we = 1; wb_waddr = a; wb_wdata = d;
    end else begin
      wb_we = 1'($urandom_range(0, 1));
      wb_waddr = '0; wb_wdata = $urandom;
    end
    hilo_we = h; hi = hv; lo = lv;
    noise();
    step();
    quiet();
  endtask

  task automatic load_entry(input int idx, input logic [1:0] k,
                            input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    load_we = 1; load_idx = IW'(idx);
    load_kind = k; load_addr = a; load_data = d;
    step();
    quiet();
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic settle();
    for (int k = 0; k < 40 && busy; k++) step();
    chk("settle_busy", busy, 0);
  endtask

  task automatic load_tp();
    load_entry(0, KG, 1, 1);
    load_entry(1, KG, 1, 2);
    load_entry(2, KG, 1, 3);
    load_entry(3, KG, 31, 32'h2C);
    load_entry(4, KH, 0, 2);
    load_entry(5, KL, 0, 32'hE);
    load_entry(6, KG, 1, 32'h48);
    load_entry(7, KE, 0, 0);
  endtask

  task automatic tp_stream(input bit corrupt);
    ev_cycle(1, 1, 1, 0, 0, 0);
    idle_cycles($urandom_range(0, 3));
    ev_cycle(1, 1, 2, 0, 0, 0);
    idle_cycles($urandom_range(0, 3));
    ev_cycle(1, 1, 3, 0, 0, 0);
    idle_cycles($urandom_range(0, 3));
    ev_cycle(1, 31, corrupt ? 32'h30 : 32'h2C, 0, 0, 0);
    if (!corrupt) begin
      idle_cycles($urandom_range(0, 3));
      ev_cycle(0, 0, 0, 1, 2, 32'hE);
      idle_cycles($urandom_range(0, 3));
      ev_cycle(1, 1, 32'h48, 0, 0, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int e, nops;
    bit            op_g  [8];
    logic [AW-1:0] op_a  [8];
    logic [DW-1:0] op_d  [8];
    logic [DW-1:0] op_hv [8];
    logic [DW-1:0] op_lv [8];
    bit            g, h;
    logic [DW-1:0] dd, hv;

    quiet();
    rst = 1;
    model_reset();
    #2 rst = 0;
    #1 cmp_all();
    chk("rst_err_code", err_code, 0);
    step();
    step();
    rst = 1;

    // reference trace, random stalls
    load_tp();
    pulse_start();
    tp_stream(0);
    settle();
    chk("tp_pass", pass, 1);
    chk("tp_cnt", match_cnt, 7);
    chk("tp_code", err_code, 0);

    // rerun from PASS with loads attempted during RUN
    pulse_start();
    ld_noise = 1;
    tp_stream(0);
    ld_noise = 0;
    settle();
    chk("rerun_pass", pass, 1);
    chk("rerun_cnt", match_cnt, 7);

    // wrong data at position 3
    pulse_start();
    tp_stream(1);
    settle();
    chk("mis_code", err_code, 1);
    chk("mis_idx", err_idx, 3);
    chk("mis_data", err_data, 32'h30);

    // three events in one cycle
    load_entry(0, KG, 1, 5);
    load_entry(1, KH, 0, 2);
    load_entry(2, KL, 0, 32'hE);
    load_entry(3, KE, 0, 0);
    pulse_start();
    ev_cycle(1, 1, 5, 1, 2, 32'hE);
    chk("burst_cnt", match_cnt, 3);
    step();
    chk("burst_pass", pass, 1);

    // extra write when the table end is reached
    load_entry(0, KG, 1, 1);
    load_entry(1, KE, 0, 0);
    pulse_start();
    idle_cycles(2);
    ev_cycle(1, 1, 1, 0, 0, 0);
    ev_cycle(1, 2, 7, 0, 0, 0);
    settle();
    chk("extra_code", err_code, 2);
    chk("extra_idx", err_idx, 1);
    chk("extra_data", err_data, 7);

    // timeout with no writes
    pulse_start();
    nb = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      nb++;
      step();
    end
    chk("to_cycles", nb, TMO);
    chk("to_code", err_code, 3);
    chk("to_idx", err_idx, 0);
    chk("to_data", err_data, 0);

    // asynchronous reset mid-run
    pulse_start();
    step();
    step();
    rst = 0;
    #1;
    model_reset();
    cmp_all();
    chk("arst_busy", busy, 0);
    step();
    rst = 1;
    pulse_start();
    step();
    chk("arst_tbl_cleared", pass, 1);

    // run off the end of a full table
    for (int i = 0; i < DEPTH; i++)
      load_entry(i, KG, AW'(i + 1), 32'h100 + i);
    load_entry(14, KE, 0, 0);
    pulse_start();
    for (int i = 0; i < DEPTH; i++)
      ev_cycle(1, AW'(i + 1), 32'h100 + i, 0, 0, 0);
    ev_cycle(1, 3, 32'hDEAD, 0, 0, 0);
    settle();
    chk("past_code", err_code, 2);
    chk("past_idx", err_idx, DEPTH);
    chk("past_data", err_data, 32'hDEAD);

    // random tables and streams
    for (int it = 0; it < 30; it++) begin
      e = 0;
      nops = 0;
      while (nops < 6 && e <= DEPTH - 3) begin
        op_g[nops] = 1'($urandom_range(0, 1));
        op_a[nops] = AW'($urandom_range(1, 31));
        op_d[nops] = $urandom;
        op_hv[nops] = $urandom;
        op_lv[nops] = $urandom;
        if (op_g[nops]) begin
          load_entry(e, KG, op_a[nops], op_d[nops]);
          e++;
        end else begin
          load_entry(e, KH, 0, op_hv[nops]);
          load_entry(e + 1, KL, 0, op_lv[nops]);
          e += 2;
        end
        nops++;
      end
      load_entry(e, KE, 0, 0);
      if ($urandom_range(0, 7) == 0) nops--;
      pulse_start();
      for (int j = 0; j < nops; j++) begin
        dd = op_d[j];
        hv = op_hv[j];
        if ($urandom_range(0, 11) == 0) begin
          dd = dd ^ (32'h1 << $urandom_range(0, 31));
          hv = hv ^ (32'h1 << $urandom_range(0, 31));
        end
        g = op_g[j];
        h = !op_g[j];
        if ($urandom_range(0, 15) == 0) begin
          g = !g;
          h = !h;
        end
        if (g && !h && j + 1 < nops && !op_g[j + 1]
            && $urandom_range(0, 1) == 1) begin
          ev_cycle(1, op_a[j], dd, 1, op_hv[j + 1], op_lv[j + 1]);
          j++;
        end else begin
          ev_cycle(g, op_a[j], dd, h, hv, op_lv[j]);
        end
        idle_cycles($urandom_range(0, 3));
      end
      settle();
      chk("rnd_done", done, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
